// File: rtl/sirv_pinport_pkg.sv
// Shared types and constants for the parametrised pin port with input filtering
// and GPIO/IOF ownership handover.
package sirv_pinport_pkg;

    typedef enum logic [1:0] {
        OWN_GPIO = 2'd0,
        OWN_IOF  = 2'd1,
        TURN     = 2'd2
    } own_state_e;

    localparam int TURN_CNT_W = 8;

    // Last value of the turnaround counter for a given turnaround length.
    function automatic logic [TURN_CNT_W-1:0] turn_last(input int turn_cyc);
        return TURN_CNT_W'(turn_cyc - 1);
    endfunction

endpackage

// File: rtl/sirv_pin_filt.sv
// One pin channel: input synchroniser, threshold glitch filter and registered
// rise/fall pulse generation on the filtered level.
module sirv_pin_filt #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_W      = 4,
    parameter logic IN_RST      = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ival,
    input  logic [FILT_W-1:0] thresh,
    output logic              filt,
    output logic              rise,
    output logic              fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [FILT_W-1:0]      cnt_q;
    logic [FILT_W-1:0]      thr_eff;
    logic [FILT_W:0]        cnt_inc;
    logic                   filt_d;

    assign s       = sync_q[SYNC_STAGES-1];
    assign thr_eff = (thresh == '0) ? FILT_W'(1) : thresh;
    // One bit wider so the increment can never wrap before the compare.
    assign cnt_inc = {1'b0, cnt_q} + (FILT_W+1)'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{IN_RST}};
            cnt_q  <= '0;
            filt   <= IN_RST;
            filt_d <= IN_RST;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ival};

            if (s == filt) begin
                cnt_q <= '0;
            end else if (cnt_inc >= {1'b0, thr_eff}) begin
                filt  <= s;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_inc[FILT_W-1:0];
            end

            // NOTE: non-blocking assignments make filt_d hold the pre-update level,
            // so the edge pulses land exactly one cycle after filt moves.
            filt_d <= filt;
            rise   <= filt & ~filt_d;
            fall   <= ~filt & filt_d;
        end
    end

endmodule

// File: rtl/sirv_pinport_filt.sv
// N-channel pin port: filtered pad inputs plus a glitch-free GPIO/IOF
// output ownership handover with an all-released turnaround window.
module sirv_pinport_filt
    import sirv_pinport_pkg::*;
#(
    parameter int           N           = 5,
    parameter int           SYNC_STAGES = 2,
    parameter int           FILT_W      = 4,
    parameter int           TURN_CYC    = 2,
    parameter logic [N-1:0] IN_RST      = {N{1'b1}},
    parameter logic [N-1:0] IE_MASK     = {N{1'b1}},
    parameter logic [N-1:0] PUE_MASK    = {N{1'b1}},
    parameter logic [N-1:0] DS_MASK     = {N{1'b0}},
    parameter logic [N-1:0] IOF_MASK    = {N{1'b1}},
    parameter logic         RST_OWNER   = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_owner,
    input  logic [FILT_W-1:0] filt_thresh,
    output logic              owner,
    output logic              busy,
    input  logic [N-1:0]      pins_i_ival,
    output logic [N-1:0]      pins_o_oval,
    output logic [N-1:0]      pins_o_oe,
    output logic [N-1:0]      pins_o_ie,
    output logic [N-1:0]      pins_o_pue,
    output logic [N-1:0]      pins_o_ds,
    input  logic [N-1:0]      gpio_oval,
    input  logic [N-1:0]      gpio_oe,
    input  logic [N-1:0]      iof_oval,
    input  logic [N-1:0]      iof_oe,
    output logic [N-1:0]      in_filt,
    output logic [N-1:0]      in_rise,
    output logic [N-1:0]      in_fall
);

    localparam own_state_e            RST_STATE = RST_OWNER ? OWN_IOF : OWN_GPIO;
    localparam logic [TURN_CNT_W-1:0] TURN_LAST = turn_last(TURN_CYC);

    own_state_e            state_q;
    logic [TURN_CNT_W-1:0] turn_cnt_q;
    logic [N-1:0]          iof_sel;
    logic [N-1:0]          gpio_sel;

    assign pins_o_ie  = IE_MASK;
    assign pins_o_pue = PUE_MASK;
    assign pins_o_ds  = DS_MASK;

    for (genvar c = 0; c < N; c++) begin : g_chan
        sirv_pin_filt #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_W      (FILT_W),
            .IN_RST      (IN_RST[c])
        ) u_filt (
            .clock  (clock),
            .reset  (reset),
            .ival   (pins_i_ival[c]),
            .thresh (filt_thresh),
            .filt   (in_filt[c]),
            .rise   (in_rise[c]),
            .fall   (in_fall[c])
        );
    end

    // Owner only changes on entry to the new own state; the turnaround always runs to completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= RST_STATE;
            turn_cnt_q <= '0;
            owner      <= RST_OWNER;
            busy       <= 1'b0;
        end else begin
            case (state_q)
                OWN_GPIO: begin
                    if (cfg_owner) begin
                        state_q <= TURN;
                        busy    <= 1'b1;
                    end
                end
                OWN_IOF: begin
                    if (!cfg_owner) begin
                        state_q <= TURN;
                        busy    <= 1'b1;
                    end
                end
                TURN: begin
                    if (turn_cnt_q == TURN_LAST) begin
                        state_q    <= cfg_owner ? OWN_IOF : OWN_GPIO;
                        owner      <= cfg_owner;
                        busy       <= 1'b0;
                        turn_cnt_q <= '0;
                    end else begin
                        turn_cnt_q <= turn_cnt_q + TURN_CNT_W'(1);
                    end
                end
                default: begin
                    state_q    <= RST_STATE;
                    owner      <= RST_OWNER;
                    busy       <= 1'b0;
                    turn_cnt_q <= '0;
                end
            endcase
        end
    end

    // Eligible channels are released entirely during TURN; ineligible ones stay on GPIO.
    assign iof_sel     = (state_q == OWN_IOF) ? IOF_MASK : '0;
    assign gpio_sel    = (state_q == TURN) ? ~IOF_MASK : ~iof_sel;
    assign pins_o_oval = (iof_sel & iof_oval) | (gpio_sel & gpio_oval);
    assign pins_o_oe   = (iof_sel & iof_oe)   | (gpio_sel & gpio_oe);

endmodule

// File: tb/tb_sirv_pinport_filt.sv
// Scoreboard bench for sirv_pinport_filt: stimulus queues cycle-tagged
// expectations, a negedge monitor pops and compares them.
module tb_sirv_pinport_filt;

    localparam int N = 5;

    typedef enum {SIG_FILT, SIG_RISE, SIG_FALL, SIG_OE, SIG_OVAL, SIG_OWNER, SIG_BUSY} sig_e;
    typedef struct {
        int         cyc;
        sig_e       sig;
        logic [4:0] exp;
        string      tag;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         cfg_owner = 1'b0;
    logic [3:0]   filt_thresh = 4'd3;
    logic         owner, busy;
    logic [N-1:0] pins_i_ival = 5'b11111;
    logic [N-1:0] pins_o_oval, pins_o_oe, pins_o_ie, pins_o_pue, pins_o_ds;
    logic [N-1:0] gpio_oval = 5'b11001;
    logic [N-1:0] gpio_oe   = 5'b10101;
    logic [N-1:0] iof_oval  = 5'b00110;
    logic [N-1:0] iof_oe    = 5'b11111;
    logic [N-1:0] in_filt, in_rise, in_fall;

    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_bad  = 0;
    exp_t sb[$];

    sirv_pinport_filt #(
        .N           (N),
        .SYNC_STAGES (2),
        .FILT_W      (4),
        .TURN_CYC    (2),
        .IOF_MASK    (5'b01111),
        .RST_OWNER   (1'b0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cfg_owner   (cfg_owner),
        .filt_thresh (filt_thresh),
        .owner       (owner),
        .busy        (busy),
        .pins_i_ival (pins_i_ival),
        .pins_o_oval (pins_o_oval),
        .pins_o_oe   (pins_o_oe),
        .pins_o_ie   (pins_o_ie),
        .pins_o_pue  (pins_o_pue),
        .pins_o_ds   (pins_o_ds),
        .gpio_oval   (gpio_oval),
        .gpio_oe     (gpio_oe),
        .iof_oval    (iof_oval),
        .iof_oe      (iof_oe),
        .in_filt     (in_filt),
        .in_rise     (in_rise),
        .in_fall     (in_fall)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [4:0] act, input logic [4:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [4:0] sample(input sig_e s);
        case (s)
            SIG_FILT:  return in_filt;
            SIG_RISE:  return in_rise;
            SIG_FALL:  return in_fall;
            SIG_OE:    return pins_o_oe;
            SIG_OVAL:  return pins_o_oval;
            SIG_OWNER: return {4'b0, owner};
            default:   return {4'b0, busy};
        endcase
    endfunction

    task automatic push(input int c, input sig_e s, input logic [4:0] v, input string tag);
        exp_t e;
        e.cyc = c;
        e.sig = s;
        e.exp = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    // Monitor: every cycle, compare and retire the expectations due now.
    always @(negedge clock) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check(sb[i].tag, sample(sb[i].sig), sb[i].exp);
                sb.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic v;

        // Reset state.
        tick(1);
        t = cyc;
        push(t, SIG_FILT,  5'b11111, "rst_filt");
        push(t, SIG_RISE,  5'b00000, "rst_rise");
        push(t, SIG_FALL,  5'b00000, "rst_fall");
        push(t, SIG_OWNER, 5'b00000, "rst_owner");
        push(t, SIG_BUSY,  5'b00000, "rst_busy");
        push(t, SIG_OE,    5'b10101, "rst_oe");
        push(t, SIG_OVAL,  5'b11001, "rst_oval");
        tick(1);
        reset = 1'b0;
        tick(3);

        // 2-cycle glitch on ch0 with threshold 3 is rejected.
        t = cyc;
        pins_i_ival[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            push(t + k, SIG_FILT, 5'b11111, "glitch2_filt");
            push(t + k, SIG_FALL, 5'b00000, "glitch2_fall");
        end
        tick(2);
        pins_i_ival[0] = 1'b1;
        tick(8);

        // 3-cycle pulse passes: falls 5 cycles after the pad edge, recovers likewise.
        t = cyc;
        pins_i_ival[0] = 1'b0;
        push(t + 4,  SIG_FILT, 5'b11111, "p3_filt_hold");
        push(t + 5,  SIG_FILT, 5'b11110, "p3_filt_fall");
        push(t + 5,  SIG_FALL, 5'b00000, "p3_fall_early");
        push(t + 6,  SIG_FALL, 5'b00001, "p3_fall_pulse");
        push(t + 7,  SIG_FALL, 5'b00000, "p3_fall_end");
        push(t + 7,  SIG_FILT, 5'b11110, "p3_filt_low");
        push(t + 8,  SIG_FILT, 5'b11111, "p3_filt_rise");
        push(t + 8,  SIG_RISE, 5'b00000, "p3_rise_early");
        push(t + 9,  SIG_RISE, 5'b00001, "p3_rise_pulse");
        push(t + 10, SIG_RISE, 5'b00000, "p3_rise_end");
        tick(3);
        pins_i_ival[0] = 1'b1;
        tick(10);

        // Threshold 0: ch1 toggling every 4 cycles follows with 3-cycle latency.
        filt_thresh = 4'd0;
        tick(2);
        for (int i = 0; i < 4; i++) begin
            t = cyc;
            v = (i % 2 == 1);
            pins_i_ival[1] = v;
            push(t + 2, SIG_FILT, v ? 5'b11101 : 5'b11111, "thr0_filt_old");
            push(t + 3, SIG_FILT, v ? 5'b11111 : 5'b11101, "thr0_filt_new");
            push(t + 3, SIG_RISE, 5'b00000, "thr0_rise_early");
            push(t + 3, SIG_FALL, 5'b00000, "thr0_fall_early");
            push(t + 4, SIG_RISE, v ? 5'b00010 : 5'b00000, "thr0_rise");
            push(t + 4, SIG_FALL, v ? 5'b00000 : 5'b00010, "thr0_fall");
            push(t + 5, SIG_RISE, 5'b00000, "thr0_rise_end");
            push(t + 5, SIG_FALL, 5'b00000, "thr0_fall_end");
            tick(4);
        end
        tick(4);

        // Handover GPIO -> IOF; ch4 is not IOF-eligible.
        t = cyc;
        cfg_owner = 1'b1;
        push(t,     SIG_OE,    5'b10101, "ho_oe_pre");
        push(t,     SIG_OWNER, 5'b00000, "ho_owner_pre");
        push(t + 1, SIG_BUSY,  5'b00001, "ho_busy1");
        push(t + 1, SIG_OE,    5'b10000, "ho_oe_turn1");
        push(t + 1, SIG_OVAL,  5'b10000, "ho_oval_turn1");
        push(t + 1, SIG_OWNER, 5'b00000, "ho_owner_turn1");
        push(t + 2, SIG_BUSY,  5'b00001, "ho_busy2");
        push(t + 2, SIG_OE,    5'b10000, "ho_oe_turn2");
        push(t + 2, SIG_OWNER, 5'b00000, "ho_owner_turn2");
        push(t + 3, SIG_BUSY,  5'b00000, "ho_busy_done");
        push(t + 3, SIG_OWNER, 5'b00001, "ho_owner_iof");
        push(t + 3, SIG_OE,    5'b11111, "ho_oe_iof");
        push(t + 3, SIG_OVAL,  5'b10110, "ho_oval_iof");
        push(t + 4, SIG_BUSY,  5'b00000, "ho_busy_stay");
        tick(5);

        // Handover IOF -> GPIO.
        t = cyc;
        cfg_owner = 1'b0;
        push(t + 1, SIG_BUSY,  5'b00001, "back_busy");
        push(t + 1, SIG_OWNER, 5'b00001, "back_owner_turn");
        push(t + 1, SIG_OE,    5'b10000, "back_oe_turn");
        push(t + 3, SIG_BUSY,  5'b00000, "back_busy_done");
        push(t + 3, SIG_OWNER, 5'b00000, "back_owner_gpio");
        push(t + 3, SIG_OE,    5'b10101, "back_oe_gpio");
        push(t + 3, SIG_OVAL,  5'b11001, "back_oval_gpio");
        tick(5);

        // Request toggled back during the second TURN cycle: full turnaround, owner stays 0.
        t = cyc;
        cfg_owner = 1'b1;
        push(t + 1, SIG_BUSY,  5'b00001, "tog_busy1");
        push(t + 1, SIG_OWNER, 5'b00000, "tog_owner1");
        push(t + 2, SIG_BUSY,  5'b00001, "tog_busy2");
        push(t + 2, SIG_OWNER, 5'b00000, "tog_owner2");
        push(t + 3, SIG_BUSY,  5'b00000, "tog_busy_done");
        push(t + 3, SIG_OWNER, 5'b00000, "tog_owner3");
        push(t + 3, SIG_OE,    5'b10101, "tog_oe_gpio");
        push(t + 4, SIG_BUSY,  5'b00000, "tog_busy_stay");
        push(t + 4, SIG_OWNER, 5'b00000, "tog_owner4");
        tick(2);
        cfg_owner = 1'b0;
        tick(5);

        // Reset mid-turn from IOF, with ch2 filtered low beforehand.
        cfg_owner = 1'b1;
        tick(5);
        pins_i_ival[2] = 1'b0;
        tick(3);
        t = cyc;
        push(t, SIG_FILT,  5'b11011, "rmt_filt_pre");
        push(t, SIG_OWNER, 5'b00001, "rmt_owner_pre");
        cfg_owner = 1'b0;
        push(t + 1, SIG_BUSY,  5'b00001, "rmt_busy_turn");
        push(t + 1, SIG_OWNER, 5'b00001, "rmt_owner_turn");
        push(t + 1, SIG_OE,    5'b10000, "rmt_oe_turn");
        tick(2);
        reset = 1'b1;
        push(t + 2, SIG_BUSY,  5'b00000, "rmt_busy_rst");
        push(t + 2, SIG_OWNER, 5'b00000, "rmt_owner_rst");
        push(t + 2, SIG_OE,    5'b10101, "rmt_oe_rst");
        push(t + 2, SIG_OVAL,  5'b11001, "rmt_oval_rst");
        push(t + 2, SIG_FILT,  5'b11111, "rmt_filt_rst");
        push(t + 2, SIG_RISE,  5'b00000, "rmt_rise_rst");
        push(t + 2, SIG_FALL,  5'b00000, "rmt_fall_rst");
        tick(1);
        reset = 1'b0;
        for (int k = 4; k <= 6; k++) begin
            push(t + k, SIG_BUSY,  5'b00000, "rmt_busy_post");
            push(t + k, SIG_OWNER, 5'b00000, "rmt_owner_post");
        end
        push(t + 5, SIG_FILT, 5'b11111, "rmt_filt_sync");
        push(t + 6, SIG_FILT, 5'b11011, "rmt_filt_refall");
        push(t + 6, SIG_FALL, 5'b00000, "rmt_fall_early");
        push(t + 7, SIG_FALL, 5'b00100, "rmt_fall_pulse");
        tick(10);

        // Any expectation never reached counts as a miscompare.
        while (sb.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s expired at cyc=%0d", sb[0].tag, sb[0].cyc);
            void'(sb.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sirv_pinport_filt.md
Name: sirv_pinport_filt

Overview:
- Parametrised N-channel pin port. Successor to the fixed JTAG pin port.
- Sits between pad cells and one peripheral (JTAG, UART, etc.).
- Adds per-channel input synchronisation, a programmable glitch filter with edge pulses, and a per-channel pad config mask.
- Adds a glitch-free ownership handover between software GPIO and the peripheral IOF, with a tri-state turnaround window.

Parameters:
- N, 5, number of pin channels.
- SYNC_STAGES, 2, input synchroniser depth (>=2).
- FILT_W, 4, filter counter/threshold width.
- TURN_CYC, 2, turnaround cycles with all oe deasserted during handover (>=1, <=255).
- IN_RST, {N{1'b1}}, reset value of synchroniser and filtered inputs (pads idle pulled-up).
- IE_MASK, {N{1'b1}}, per-channel input-enable constant.
- PUE_MASK, {N{1'b1}}, per-channel pull-up constant.
- DS_MASK, {N{1'b0}}, per-channel drive-strength constant.
- IOF_MASK, {N{1'b1}}, channels eligible for peripheral ownership; a 0 bit means always GPIO-owned.
- RST_OWNER, 1'b0, owner after reset (0 = GPIO, 1 = IOF).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-high reset
- cfg_owner  in  1  requested owner (0 GPIO, 1 IOF)
- filt_thresh  in  FILT_W  glitch filter threshold in cycles; 0 and 1 both mean minimal filtering
- owner  out  1  current owner
- busy  out  1  turnaround in progress
- pins_i_ival  in  N  raw pad inputs
- pins_o_oval  out  N  pad output value
- pins_o_oe  out  N  pad output enable
- pins_o_ie  out  N  pad input enable
- pins_o_pue  out  N  pad pull-up enable
- pins_o_ds  out  N  pad drive strength
- gpio_oval  in  N  software output value
- gpio_oe  in  N  software output enable
- iof_oval  in  N  peripheral output value
- iof_oe  in  N  peripheral output enable
- in_filt  out  N  filtered, synchronised input level
- in_rise  out  N  one-cycle pulse on filtered 0->1
- in_fall  out  N  one-cycle pulse on filtered 1->0

Behaviour:
- Reset, asynchronous:
  - sync chain = IN_RST, in_filt = IN_RST, filter counters = 0.
  - in_rise = in_fall = 0.
  - FSM = own state of RST_OWNER; owner = RST_OWNER; busy = 0; turn counter = 0.
- pins_o_ie/pue/ds are tied to IE_MASK/PUE_MASK/DS_MASK and are independent of state.
- Synchroniser: SYNC_STAGES flops per channel. s = last stage.
- Filter, per channel, each cycle:
  - If s == in_filt: counter <= 0.
  - Else if counter+1 >= max(filt_thresh,1): in_filt <= s, counter <= 0.
  - Else: counter <= counter+1.
  - Any return of s to in_filt before the threshold resets the counter, so a glitch shorter than the threshold is discarded.
  - Latency from pad edge to in_filt = SYNC_STAGES + max(filt_thresh,1) cycles.
  - Counter saturates; no wrap.
  - A change of filt_thresh takes effect the next cycle, compared against the current counter.
- Edges: in_rise/in_fall are registered and asserted the cycle after in_filt changes, for 1 cycle. in_rise and in_fall never assert together on one channel.
- FSM states:
  - OWN_GPIO → TURN when cfg_owner = 1.
  - OWN_IOF → TURN when cfg_owner = 0.
  - TURN: the turn counter counts 0..TURN_CYC-1. At the last count the FSM goes to the own state given by cfg_owner sampled in that cycle, and the counter clears.
  - A cfg_owner toggle during TURN does not restart or abort the turnaround. If the final sample equals the previous owner, the FSM returns to it after a full turnaround.
- Outputs per channel c:
  - TURN: oe = 0, oval = 0.
  - OWN_IOF and IOF_MASK[c] = 1: oval/oe = iof_oval/iof_oe.
  - Otherwise: oval/oe = gpio_oval/gpio_oe.
  - These outputs are combinational from state and inputs.
  - owner changes on the cycle the FSM enters the new own state. busy = (state == TURN).
  - Channels with IOF_MASK = 0 are unaffected by TURN and stay driven by GPIO throughout.
- Reset asserted mid-turnaround: immediate return to RST_OWNER, turn counter cleared.
- Filter path is independent of ownership and keeps running during TURN.

Decomposition:
- Package sirv_pinport_pkg:
  - FSM state encoding: OWN_GPIO = 2'd0, OWN_IOF = 2'd1, TURN = 2'd2.
  - Turn counter width constant: 8 bits.
- Sub-module sirv_pin_filt: one channel of synchroniser, filter counter and edge pulse generator. Generated N times.
- FSM and output mux stay in the top.

Test Plan:
- Reset check: N=5, assert reset mid-run → all in_filt = 1, in_rise = in_fall = 0, owner = 0, busy = 0, pins_o_oe = gpio_oe combinationally.
- Glitch reject: filt_thresh=3, pad 0 pulse for 2 cycles → in_filt stays 1, no in_fall. Pulse of 3 cycles → in_filt falls exactly SYNC_STAGES+3 = 5 cycles after the pad edge, in_fall pulses 1 cycle later.
- Threshold 0: filt_thresh=0, pad toggles every 4 cycles → in_filt follows with 3-cycle latency, alternating rise/fall pulses.
- Handover: TURN_CYC=2, iof_oe=all 1, cfg_owner 0→1 → busy high and oe=0 for 2 cycles, then owner=1 and pins_o_oe = iof_oe on IOF_MASK channels. A channel with IOF_MASK=0 keeps gpio_oe throughout.
- Toggle mid-turn: cfg_owner 0→1, then back to 0 in the second TURN cycle → FSM returns to OWN_GPIO after 2 cycles, owner never reads 1.
- Reset mid-turn: assert reset during TURN → busy=0 and owner=RST_OWNER immediately (asynchronous). After release, no spurious turnaround while cfg_owner = RST_OWNER.
